// File: rtl/cpu_pkg.sv
// Shared definitions for the fetch stage and IF/ID register:
// the FSM state encoding, the nop word and the default reset PC.
package cpu_pkg;

  typedef enum logic [1:0] {
    ST_BOOT   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } fetch_state_t;

  localparam logic [31:0] NOP_WORD         = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // Redirect targets are forced onto a word boundary.
  function automatic logic [31:0] alignPc(input logic [31:0] target);
    return {target[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/ifid_reg.sv
// IF/ID pipeline register with bubble, hold and load controls.
// A bubble writes the nop word with valid and pc4 cleared.
module ifid_reg
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_bubble,
  input  logic        i_hold,
  input  logic        i_load,
  input  logic [31:0] i_inst,
  input  logic [31:0] i_pc4,
  output logic        o_valid,
  output logic [31:0] o_inst,
  output logic [31:0] o_pc4
);

  logic        r_valid;
  logic [31:0] r_inst;
  logic [31:0] r_pc4;

  // Bubble outranks hold, hold outranks load; with no control asserted the contents stay put.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_inst  <= NOP_WORD;
      r_pc4   <= 32'h0;
    end else if (i_bubble) begin
      r_valid <= 1'b0;
      r_inst  <= NOP_WORD;
      r_pc4   <= 32'h0;
    end else if (i_hold) begin
      r_valid <= r_valid;
      r_inst  <= r_inst;
      r_pc4   <= r_pc4;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_inst  <= i_inst;
      r_pc4   <= i_pc4;
    end
  end

  assign o_valid = r_valid;
  assign o_inst  = r_inst;
  assign o_pc4   = r_pc4;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, BOOT/RUN/HALTED control FSM,
// fetch counter and sticky misalignment flag feeding the IF/ID register.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          IMEM_AW  = 9
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_data,
  input  logic               stall,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_pc,
  input  logic               halt_req,
  output logic               ifid_valid,
  output logic [31:0]        ifid_inst,
  output logic [31:0]        ifid_pc4,
  output logic [31:0]        pc,
  output logic [31:0]        fetch_cnt,
  output logic               misalign,
  output logic               halted
);

  fetch_state_t r_state;
  logic [31:0]  r_pc;
  logic [31:0]  r_fetchCnt;
  logic         r_misalign;
  logic         r_halted;

  logic [31:0]  w_pc4;
  logic         w_redirect;
  logic         w_hold;
  logic         w_load;
  logic         w_bubble;

  assign w_pc4      = r_pc + 32'd4;
  assign w_redirect = redirect_valid && (r_state != ST_BOOT);
  assign w_hold     = (r_state == ST_RUN) && !redirect_valid && stall;
  assign w_load     = (r_state == ST_RUN) && !redirect_valid && !stall;
  assign w_bubble   = !w_hold && !w_load;

  // Redirect beats stall beats halt; halt still captures the current word before stopping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_BOOT;
      r_pc       <= RESET_PC;
      r_fetchCnt <= 32'h0;
      r_misalign <= 1'b0;
      r_halted   <= 1'b0;
    end else begin
      if (w_redirect) begin
        r_pc <= alignPc(redirect_pc);
        if (redirect_pc[1:0] != 2'b00) begin
          r_misalign <= 1'b1;
        end
      end else if (w_load) begin
        r_pc       <= w_pc4;
        r_fetchCnt <= r_fetchCnt + 32'd1;
      end
      case (r_state)
        ST_BOOT: begin
          r_state  <= ST_RUN;
          r_halted <= 1'b0;
        end
        ST_RUN: begin
          if (!redirect_valid && !stall && halt_req) begin
            r_state  <= ST_HALTED;
            r_halted <= 1'b1;
          end
        end
        ST_HALTED: begin
          if (redirect_valid) begin
            r_state  <= ST_RUN;
            r_halted <= 1'b0;
          end
        end
        default: begin
          r_state  <= ST_BOOT;
          r_halted <= 1'b0;
        end
      endcase
    end
  end

  ifid_reg u_ifid (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_bubble (w_bubble),
    .i_hold   (w_hold),
    .i_load   (w_load),
    .i_inst   (imem_data),
    .i_pc4    (w_pc4),
    .o_valid  (ifid_valid),
    .o_inst   (ifid_inst),
    .o_pc4    (ifid_pc4)
  );

  assign imem_addr = r_pc[IMEM_AW-1:0];
  assign pc        = r_pc;
  assign fetch_cnt = r_fetchCnt;
  assign misalign  = r_misalign;
  assign halted    = r_halted;

endmodule
